// File: rtl/bdu_pkg.sv
// bdu_pkg: shared decode-stage types, opcode constants and AXI response codes.
// Used by the instruction queue and by later pipeline stages.
package bdu_pkg;

    typedef enum logic [2:0] {
        INST_NONE = 3'd0,
        INST_R    = 3'd1,
        INST_I    = 3'd2,
        INST_S    = 3'd3,
        INST_B    = 3'd4,
        INST_U    = 3'd5,
        INST_J    = 3'd6,
        INST_PRIV = 3'd7
    } optype_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    function automatic logic rresp_fault(input logic [1:0] resp);
        return (resp == RRESP_SLVERR) || (resp == RRESP_DECERR);
    endfunction

endpackage

// File: rtl/bdu_ibuf_inst_decode.sv
// inst_decode: combinational RV32 field extraction, format classification
// and sign-extended immediate generation.
module inst_decode
    import bdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [11:0]     csr_addr_o,
    output logic [2:0]      optype_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opcode;
    optype_e     optype;
    logic [31:0] imm32;

    assign opcode     = inst_i[6:0];
    assign rd_o       = inst_i[11:7];
    assign funct3_o   = inst_i[14:12];
    assign rs1_o      = inst_i[19:15];
    assign rs2_o      = inst_i[24:20];
    assign funct7_o   = inst_i[31:25];
    assign csr_addr_o = inst_i[31:20];
    assign optype_o   = optype;

    always_comb begin
        optype = INST_NONE;
        unique case (1'b1)
            opcode == OPC_OP:       optype = INST_R;
            opcode == OPC_OP_IMM,
            opcode == OPC_LOAD,
            opcode == OPC_JALR,
            opcode == OPC_MISC_MEM: optype = INST_I;
            opcode == OPC_STORE:    optype = INST_S;
            opcode == OPC_BRANCH:   optype = INST_B;
            opcode == OPC_LUI,
            opcode == OPC_AUIPC:    optype = INST_U;
            opcode == OPC_JAL:      optype = INST_J;
            opcode == OPC_SYSTEM:   optype = INST_PRIV;
            default:                optype = INST_NONE;
        endcase
    end

    always_comb begin
        imm32 = '0;
        unique case (optype)
            INST_I, INST_PRIV:
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            INST_S:
                imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            INST_B:
                imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            INST_U:
                imm32 = {inst_i[31:12], 12'b0};
            INST_J:
                imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                         inst_i[20], inst_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/bdu_ibuf.sv
// bdu_ibuf: in-order fetch queue between IFU requests and AXI R beats.
// Define IBUF_BYPASS_EN to issue a head beat in the cycle it arrives.
module bdu_ibuf
    import bdu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            ifu_valid_i,
    output logic            ifu_ready_o,
    input  logic [XLEN-1:0] ifu_pc_i,
    input  logic [XLEN-1:0] ifu_snpc_i,
    input  logic [31:0]     rdata_i,
    input  logic            rvalid_i,
    input  logic [1:0]      rresp_i,
    output logic            rready_o,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [XLEN-1:0] dec_snpc_o,
    output logic [31:0]     dec_inst_o,
    output logic [4:0]      dec_rs1_o,
    output logic [4:0]      dec_rs2_o,
    output logic [4:0]      dec_rd_o,
    output logic [XLEN-1:0] dec_imm_o,
    output logic [2:0]      dec_optype_o,
    output logic [2:0]      dec_funct3_o,
    output logic [6:0]      dec_funct7_o,
    output logic [11:0]     dec_csr_addr_o,
    output logic            dec_fault_o
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]   unfilled_cnt_q, unfilled_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] pc_d   [DEPTH];
    logic [XLEN-1:0] snpc_q [DEPTH];
    logic [XLEN-1:0] snpc_d [DEPTH];
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     inst_d [DEPTH];
    logic [DEPTH-1:0] fault_q, fault_d;

    logic        fire;
    logic        beat_acc;
    logic        drop_beat;
    logic        fill_beat;
    logic        fill_wr;
    logic        pop;
    logic        bypass;
    logic        beat_fault;
    logic [31:0] beat_inst;
    logic [31:0] head_inst;
    logic        head_fault;

    assign ifu_ready_o = ({1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q}) < DEPTH_C;
    assign rready_o    = (unfilled_cnt_q != '0) | (drop_cnt_q != '0);

    assign fire      = ifu_valid_i & ifu_ready_o;
    assign beat_acc  = rvalid_i & rready_o;
    assign drop_beat = beat_acc & (drop_cnt_q != '0);
    assign fill_beat = beat_acc & (drop_cnt_q == '0);

    // Faulting beats never expose their data as an instruction.
    assign beat_fault = rresp_fault(rresp_i);
    assign beat_inst  = beat_fault ? 32'h0 : rdata_i;

`ifdef IBUF_BYPASS_EN
    assign bypass = fill_beat & (alloc_cnt_q == unfilled_cnt_q);
`else
    assign bypass = 1'b0;
`endif

    assign dec_valid_o = (alloc_cnt_q != unfilled_cnt_q) | bypass;
    assign pop         = dec_valid_o & dec_ready_i;
    assign fill_wr     = fill_beat & ~(bypass & pop);

    assign head_inst  = bypass ? beat_inst  : inst_q[rd_ptr_q];
    assign head_fault = bypass ? beat_fault : fault_q[rd_ptr_q];

    assign dec_pc_o    = pc_q[rd_ptr_q];
    assign dec_snpc_o  = snpc_q[rd_ptr_q];
    assign dec_inst_o  = head_inst;
    assign dec_fault_o = head_fault;

    inst_decode #(.XLEN(XLEN)) u_dec (
        .inst_i     (head_inst),
        .rs1_o      (dec_rs1_o),
        .rs2_o      (dec_rs2_o),
        .rd_o       (dec_rd_o),
        .funct3_o   (dec_funct3_o),
        .funct7_o   (dec_funct7_o),
        .csr_addr_o (dec_csr_addr_o),
        .optype_o   (dec_optype_o),
        .imm_o      (dec_imm_o)
    );

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        fill_ptr_d     = fill_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        alloc_cnt_d    = alloc_cnt_q;
        unfilled_cnt_d = unfilled_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        pc_d           = pc_q;
        snpc_d         = snpc_q;
        inst_d         = inst_q;
        fault_d        = fault_q;

        if (flush_i) begin
            // Every outstanding fetch still owes a beat that must be swallowed.
            drop_cnt_d     = drop_cnt_q + unfilled_cnt_q - CW'(beat_acc);
            fill_ptr_d     = '0;
            rd_ptr_d       = '0;
            wr_ptr_d       = PW'(fire);
            alloc_cnt_d    = CW'(fire);
            unfilled_cnt_d = CW'(fire);
            if (fire) begin
                pc_d[0]   = ifu_pc_i;
                snpc_d[0] = ifu_snpc_i;
            end
        end else begin
            if (drop_beat) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (fill_beat) begin
                fill_ptr_d = fill_ptr_q + 1'b1;
            end
            if (fill_wr) begin
                inst_d[fill_ptr_q]  = beat_inst;
                fault_d[fill_ptr_q] = beat_fault;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (fire) begin
                pc_d[wr_ptr_q]   = ifu_pc_i;
                snpc_d[wr_ptr_q] = ifu_snpc_i;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            alloc_cnt_d    = alloc_cnt_q + CW'(fire) - CW'(pop);
            unfilled_cnt_d = unfilled_cnt_q + CW'(fire) - CW'(fill_beat);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            fill_ptr_q     <= '0;
            rd_ptr_q       <= '0;
            alloc_cnt_q    <= '0;
            unfilled_cnt_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            fill_ptr_q     <= fill_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            alloc_cnt_q    <= alloc_cnt_d;
            unfilled_cnt_q <= unfilled_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Entry payload is only meaningful under the counters, so it needs no reset.
    always_ff @(posedge clk_i) begin
        pc_q    <= pc_d;
        snpc_q  <= snpc_d;
        inst_q  <= inst_d;
        fault_q <= fault_d;
    end

endmodule

// File: tb/tb_bdu_ibuf.sv
// tb_bdu_ibuf: directed and random stimulus for bdu_ibuf, checked against
// a queue-based reference model of outstanding and filled fetches.
module tb_bdu_ibuf;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        ifu_valid_i = 1'b0;
    logic        ifu_ready_o;
    logic [31:0] ifu_pc_i = '0;
    logic [31:0] ifu_snpc_i = '0;
    logic [31:0] rdata_i = '0;
    logic        rvalid_i = 1'b0;
    logic [1:0]  rresp_i = '0;
    logic        rready_o;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b0;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_snpc_o;
    logic [31:0] dec_inst_o;
    logic [4:0]  dec_rs1_o;
    logic [4:0]  dec_rs2_o;
    logic [4:0]  dec_rd_o;
    logic [31:0] dec_imm_o;
    logic [2:0]  dec_optype_o;
    logic [2:0]  dec_funct3_o;
    logic [6:0]  dec_funct7_o;
    logic [11:0] dec_csr_addr_o;
    logic        dec_fault_o;

    always #5 clk = ~clk;

    bdu_ibuf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .ifu_valid_i    (ifu_valid_i),
        .ifu_ready_o    (ifu_ready_o),
        .ifu_pc_i       (ifu_pc_i),
        .ifu_snpc_i     (ifu_snpc_i),
        .rdata_i        (rdata_i),
        .rvalid_i       (rvalid_i),
        .rresp_i        (rresp_i),
        .rready_o       (rready_o),
        .dec_valid_o    (dec_valid_o),
        .dec_ready_i    (dec_ready_i),
        .dec_pc_o       (dec_pc_o),
        .dec_snpc_o     (dec_snpc_o),
        .dec_inst_o     (dec_inst_o),
        .dec_rs1_o      (dec_rs1_o),
        .dec_rs2_o      (dec_rs2_o),
        .dec_rd_o       (dec_rd_o),
        .dec_imm_o      (dec_imm_o),
        .dec_optype_o   (dec_optype_o),
        .dec_funct3_o   (dec_funct3_o),
        .dec_funct7_o   (dec_funct7_o),
        .dec_csr_addr_o (dec_csr_addr_o),
        .dec_fault_o    (dec_fault_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] snpc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    ent_t pend[$];
    ent_t full[$];
    int   drop = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic cyc();
        bit   e_ready, e_rready, e_valid, byp, fire, beat, pop;
        ent_t head;
        #1;
        if (rst_ni) begin
            e_ready  = (pend.size() + full.size() + drop) < DEPTH;
            e_rready = (pend.size() != 0) || (drop != 0);
            beat     = rvalid_i && e_rready;
            byp      = 1'b0;
`ifdef IBUF_BYPASS_EN
            byp = beat && (drop == 0) && (full.size() == 0);
`endif
            e_valid = (full.size() != 0) || byp;
            chk("ifu_ready", 32'(ifu_ready_o), 32'(e_ready));
            chk("rready", 32'(rready_o), 32'(e_rready));
            chk("dec_valid", 32'(dec_valid_o), 32'(e_valid));
            if (e_valid) begin
                if (byp) begin
                    head       = pend[0];
                    head.fault = rresp_i[1];
                    head.inst  = rresp_i[1] ? 32'h0 : rdata_i;
                end else begin
                    head = full[0];
                end
                chk("dec_pc", dec_pc_o, head.pc);
                chk("dec_snpc", dec_snpc_o, head.snpc);
                chk("dec_inst", dec_inst_o, head.inst);
                chk("dec_fault", 32'(dec_fault_o), 32'(head.fault));
                chk("dec_rd", 32'(dec_rd_o), 32'(head.inst[11:7]));
                chk("dec_rs1", 32'(dec_rs1_o), 32'(head.inst[19:15]));
                chk("dec_rs2", 32'(dec_rs2_o), 32'(head.inst[24:20]));
                chk("dec_funct3", 32'(dec_funct3_o), 32'(head.inst[14:12]));
                chk("dec_funct7", 32'(dec_funct7_o), 32'(head.inst[31:25]));
                chk("dec_csr", 32'(dec_csr_addr_o), 32'(head.inst[31:20]));
            end
            fire = ifu_valid_i && e_ready;
            pop  = dec_ready_i && e_valid;
            if (flush_i) begin
                drop = drop + pend.size() - (beat ? 1 : 0);
                pend.delete();
                full.delete();
            end else begin
                if (pop && full.size() != 0) begin
                    void'(full.pop_front());
                    pop = 1'b0;
                end
                if (beat) begin
                    if (drop > 0) begin
                        drop--;
                    end else begin
                        ent_t e;
                        e       = pend.pop_front();
                        e.fault = rresp_i[1];
                        e.inst  = rresp_i[1] ? 32'h0 : rdata_i;
                        full.push_back(e);
                    end
                end
                if (pop) void'(full.pop_front());
            end
            if (fire) pend.push_back('{ifu_pc_i, ifu_snpc_i, 32'h0, 1'b0});
        end else begin
            pend.delete();
            full.delete();
            drop = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit iv, input logic [31:0] pc, input bit rv,
                        input logic [31:0] data, input logic [1:0] resp,
                        input bit dr, input bit fl);
        ifu_valid_i = iv;
        ifu_pc_i    = pc;
        ifu_snpc_i  = pc + 32'd4;
        rvalid_i    = rv;
        rdata_i     = data;
        rresp_i     = resp;
        dec_ready_i = dr;
        flush_i     = fl;
        cyc();
    endtask

    task automatic dec_case(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [2:0] ot, input logic [31:0] imm);
        step(1, pc, 0, 0, 0, 0, 0);
        step(0, 0, 1, inst, 2'b00, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("optype", 32'(dec_optype_o), 32'(ot));
        chk("imm", dec_imm_o, imm);
        step(0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc();
        cyc();
        rst_ni = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);

        // unsolicited beat on an empty queue
        step(0, 0, 1, 32'hdeadbeef, 0, 1, 0);

        dec_case(32'h80000000, 32'h00500093, 3'd2, 32'h00000005);
        dec_case(32'h80000004, 32'hFE512E23, 3'd3, 32'hFFFFFFFC);
        dec_case(32'h80000008, 32'hFE208CE3, 3'd4, 32'hFFFFFFF8);
        dec_case(32'h8000000C, 32'h123451B7, 3'd5, 32'h12345000);
        dec_case(32'h80000010, 32'h001000EF, 3'd6, 32'h00000800);
        dec_case(32'h80000014, 32'h002081B3, 3'd1, 32'h00000000);
        dec_case(32'h80000018, 32'h30009073, 3'd7, 32'h00000300);
        dec_case(32'h8000001C, 32'hFFFFFFFF, 3'd0, 32'h00000000);

        // fill the queue, then feed beats with the consumer ready
        for (int i = 0; i < DEPTH; i++)
            step(1, 32'h80000020 + 32'(4 * i), 0, 0, 0, 0, 0);
        step(1, 32'h80000040, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 1, 32'h00100013 + 32'(i << 7), 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);

        // backpressure on two filled entries
        step(1, 32'h80000050, 0, 0, 0, 0, 0);
        step(1, 32'h80000054, 1, 32'h00A00113, 0, 0, 0);
        step(0, 0, 1, 32'h00B00193, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);

        // flush with two fetches still owed a beat
        step(1, 32'h80000060, 0, 0, 0, 0, 0);
        step(1, 32'h80000064, 1, 32'h00100093, 0, 0, 0);
        step(1, 32'h80000068, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        step(1, 32'h80000100, 0, 0, 0, 1, 0);
        step(0, 0, 1, 32'h11111111, 0, 1, 0);
        step(0, 0, 1, 32'h22222222, 0, 1, 0);
        step(0, 0, 1, 32'h00700393, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_flush_pc", dec_pc_o, 32'h80000100);
        step(0, 0, 0, 0, 0, 1, 0);

        // faulting beat followed by an EXOKAY beat
        step(1, 32'h80000200, 0, 0, 0, 0, 0);
        step(1, 32'h80000204, 1, 32'h00500093, 2'b10, 0, 0);
        step(0, 0, 1, 32'h00600113, 2'b01, 0, 0);
        chk("fault_flag", 32'(dec_fault_o), 32'd1);
        chk("fault_inst", dec_inst_o, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);

        // reset with entries pending
        step(1, 32'h80000300, 0, 0, 0, 0, 0);
        step(1, 32'h80000304, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h12345678, 0, 1, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom & 32'hFFFFFFFC,
                 $urandom_range(0, 2) != 0, $urandom,
                 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 12; i++) step(0, 0, 1, $urandom, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
